// File: rtl/fb_scanout.sv
// fb_scanout: frame-buffer read-address generator with double buffering and
// sync/draw realignment to the BRAM read latency.
module fb_scanout #(
  parameter int START_X = 390,
  parameter int START_Y = 390,
  parameter int END_X = 634,
  parameter int END_Y = 765,
  parameter int ADDR_WIDTH = 18,
  parameter int LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  ad_in,
  input  logic                  nf_in,
  input  logic                  swap_req_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [11:0]           ram_data_in,
  output logic [3:0]            vga_r_out,
  output logic [3:0]            vga_g_out,
  output logic [3:0]            vga_b_out,
  output logic                  hs_out,
  output logic                  vs_out,
  output logic                  buf_sel_out,
  output logic                  swap_ack_out,
  output logic                  overrun_out
);
  localparam logic [ADDR_WIDTH-1:0] RP = ADDR_WIDTH'((END_X - START_X) * (END_Y - START_Y));
  localparam logic [10:0] SX = 11'(START_X);
  localparam logic [10:0] EX = 11'(END_X);
  localparam logic [9:0] SY = 10'(START_Y);
  localparam logic [9:0] EY = 10'(END_Y);
  logic in_region, at_end, do_swap;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic buf_sel_q, buf_sel_d, pend_q, pend_d, ack_q, ack_d;
  logic synced_q, synced_d, full_q, full_d, ovr_q, ovr_d;
  // each stage: {hs, vs, ad, in_region, synced}
  logic [LATENCY-1:0][4:0] pipe_q, pipe_d;
  always_comb begin
    in_region = hcount_in >= SX && hcount_in < EX && vcount_in >= SY && vcount_in < EY;
    at_end = offset_q == RP - 1'b1;
    do_swap = nf_in & (pend_q | swap_req_in);
    offset_d = nf_in ? '0 : (in_region && !at_end) ? offset_q + 1'b1 : offset_q;
    // full marks that the last legitimate pixel was consumed; any further one overruns
    full_d = nf_in ? 1'b0 : full_q | (in_region & at_end);
    ovr_d = ovr_q | (!nf_in & in_region & full_q);
    buf_sel_d = buf_sel_q ^ do_swap;
    pend_d = !do_swap & (pend_q | swap_req_in);
    ack_d = do_swap;
    synced_d = synced_q | nf_in;
    pipe_d = '0;
    pipe_d[0] = {hs_in, vs_in, ad_in, in_region, synced_q};
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    ram_addr_out = in_region ? (buf_sel_q ? RP : '0) + offset_q : '0;
    {vga_r_out, vga_g_out, vga_b_out} = (&pipe_q[LATENCY-1][2:0]) ? ram_data_in : 12'h0;
    hs_out = pipe_q[LATENCY-1][4];
    vs_out = pipe_q[LATENCY-1][3];
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      offset_q <= '0;
      buf_sel_q <= 1'b0;
      pend_q <= 1'b0;
      ack_q <= 1'b0;
      synced_q <= 1'b0;
      full_q <= 1'b0;
      ovr_q <= 1'b0;
      pipe_q <= '0;
    end else begin
      offset_q <= offset_d;
      buf_sel_q <= buf_sel_d;
      pend_q <= pend_d;
      ack_q <= ack_d;
      synced_q <= synced_d;
      full_q <= full_d;
      ovr_q <= ovr_d;
      pipe_q <= pipe_d;
    end
  end
  assign buf_sel_out = buf_sel_q;
  assign swap_ack_out = ack_q;
  assign overrun_out = ovr_q;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed frame sweeps on a shrunken region against a behavioural
// model, with a scoreboard queue tracking the delayed VGA outputs.
module tb_fb_scanout;
  localparam int SX = 6, EX = 14, SY = 4, EY = 10, AW = 8, HT = 24, VT = 14;
  localparam int RP = (EX - SX) * (EY - SY);
  localparam int NF_POS = HT * VT - 1;
  typedef struct packed {logic hs; logic vs; logic [11:0] rgb;} exp_t;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0] vcount_in = '0;
  logic hs_in = 0, vs_in = 0, ad_in = 0, nf_in = 0, swap_req_in = 0;
  logic [AW-1:0] ram_addr_out;
  logic [11:0] ram_data_in = '0, rd1 = '0;
  logic [3:0] vga_r_out, vga_g_out, vga_b_out;
  logic hs_out, vs_out, buf_sel_out, swap_ack_out, overrun_out;
  int n_chk = 0, n_err = 0, m_cnt = 0;
  bit m_buf, m_pend, m_ack, m_sync, m_ovr;
  exp_t q[$];
  fb_scanout #(.START_X(SX), .START_Y(SY), .END_X(EX), .END_Y(EY), .ADDR_WIDTH(AW), .LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hs_in(hs_in), .vs_in(vs_in), .ad_in(ad_in), .nf_in(nf_in), .swap_req_in(swap_req_in),
    .ram_addr_out(ram_addr_out), .ram_data_in(ram_data_in),
    .vga_r_out(vga_r_out), .vga_g_out(vga_g_out), .vga_b_out(vga_b_out),
    .hs_out(hs_out), .vs_out(vs_out), .buf_sel_out(buf_sel_out),
    .swap_ack_out(swap_ack_out), .overrun_out(overrun_out)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [11:0] bram(input logic [AW-1:0] a);
    return 12'hABC ^ {4'h0, a};
  endfunction
  // two-cycle BRAM model addressed by the DUT
  always @(posedge clk_in) begin
    rd1 <= bram(ram_addr_out);
    ram_data_in <= rd1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reset_model();
    m_cnt = 0; m_buf = 0; m_pend = 0; m_ack = 0; m_sync = 0; m_ovr = 0;
    q.delete();
    q.push_back('0);
    q.push_back('0);
  endtask
  task automatic cyc(input int h, input int v, input bit nf, input bit req);
    bit rg;
    logic [AW-1:0] ea;
    exp_t e;
    @(posedge clk_in); #1;
    hcount_in = 11'(h); vcount_in = 10'(v);
    hs_in = h >= 18 && h < 21; vs_in = v == 12; ad_in = h < 16 && v < 12;
    nf_in = nf; swap_req_in = req;
    #3;
    rg = h >= SX && h < EX && v >= SY && v < EY;
    ea = rg ? AW'((m_buf ? RP : 0) + (m_cnt < RP ? m_cnt : RP - 1)) : '0;
    chk("addr", 32'(ram_addr_out), 32'(ea));
    chk("buf_sel", 32'(buf_sel_out), 32'(m_buf));
    chk("swap_ack", 32'(swap_ack_out), 32'(m_ack));
    chk("overrun", 32'(overrun_out), 32'(m_ovr));
    e = q.pop_front();
    chk("hs_out", 32'(hs_out), 32'(e.hs));
    chk("vs_out", 32'(vs_out), 32'(e.vs));
    chk("rgb", 32'({vga_r_out, vga_g_out, vga_b_out}), 32'(e.rgb));
    e.hs = hs_in; e.vs = vs_in;
    e.rgb = (rg && ad_in && m_sync) ? bram(ea) : 12'h0;
    q.push_back(e);
    if (nf) m_cnt = 0;
    else if (rg) begin
      if (m_cnt >= RP) m_ovr = 1;
      m_cnt++;
    end
    m_ack = nf && (m_pend || req);
    if (m_ack) begin m_buf = !m_buf; m_pend = 0; end
    else if (req) m_pend = 1;
    if (nf) m_sync = 1;
  endtask
  task automatic do_reset(input int h, input int v);
    @(posedge clk_in); #1;
    hcount_in = 11'(h); vcount_in = 10'(v);
    hs_in = 1; vs_in = 1; ad_in = 1; nf_in = 0; swap_req_in = 0;
    rst_in = 1;
    #1;
    chk("rst_addr", 32'(ram_addr_out), 32'h0);
    chk("rst_rgb", 32'({vga_r_out, vga_g_out, vga_b_out}), 32'h0);
    chk("rst_hs", 32'(hs_out), 32'h0);
    chk("rst_vs", 32'(vs_out), 32'h0);
    chk("rst_buf_sel", 32'(buf_sel_out), 32'h0);
    chk("rst_ack", 32'(swap_ack_out), 32'h0);
    chk("rst_overrun", 32'(overrun_out), 32'h0);
    repeat (2) @(posedge clk_in);
    #1;
    hcount_in = '0; vcount_in = '0; hs_in = 0; vs_in = 0; ad_in = 0;
    rst_in = 0;
    reset_model();
  endtask
  // r1/r2: linear positions of swap requests, rp: reset position (-1 = none)
  task automatic frame(input int r1, input int r2, input bit nf_en, input int rp);
    int p;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        p = v * HT + h;
        if (p == rp) do_reset(h, v);
        else cyc(h, v, nf_en && p == NF_POS, p == r1 || p == r2);
      end
  endtask
  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("init_addr", 32'(ram_addr_out), 32'h0);
    chk("init_rgb", 32'({vga_r_out, vga_g_out, vga_b_out}), 32'h0);
    chk("init_buf_sel", 32'(buf_sel_out), 32'h0);
    chk("init_overrun", 32'(overrun_out), 32'h0);
    rst_in = 0;
    reset_model();
    frame(-1, -1, 1, -1);
    frame(-1, -1, 1, -1);
    frame(5 * HT + 3, -1, 1, -1);
    frame(NF_POS, -1, 1, -1);
    frame(30, 300, 1, -1);
    frame(-1, -1, 1, -1);
    frame(30, -1, 1, 6 * HT + 8);
    frame(-1, -1, 1, -1);
    frame(-1, -1, 0, -1);
    frame(-1, -1, 1, -1);
    frame(-1, -1, 1, -1);
    chk("overrun_sticky", 32'(overrun_out), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
